albacore_biu: RTL

Parametrised bus interface unit for the next-generation albacore core: it sits between the core's memory port and external memory and replaces the single-cycle memory assumption with a valid/ready handshake. Writes are posted into a WBUF_DEPTH-entry FIFO and drained in the background. Reads stall the core until the memory returns data. Width, address size and buffer depth are parameters.

---
 rtl/albacore_biu.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/albacore_biu.sv
// albacore_biu
// ------------
// Bus interface unit between the albacore core memory port and external
// memory. Core writes are posted into a WBUF_DEPTH-entry FIFO and drained to
// memory in the background. Core reads stall until memory returns the data.
// A read never passes an older buffered write.
//
// Optional feature macro: ALBACORE_BIU_FWD_EN
//   When defined, a read whose address hits a buffered write is answered
//   from the newest matching FIFO entry. No drain and no memory read happen
//   for that read. When undefined, no address comparators are built and
//   every read first drains the buffer.
//
// Parameters
//   DATA_W      data word width
//   ADDR_W      word-address width
//   WBUF_DEPTH  write-buffer entries (power of two, >= 2)
//
// Ports
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   core_req       core access request, held stable until accepted
//   core_we        1 = write, 0 = read
//   core_addr      access address
//   core_wdata     write data
//   core_stall     request not accepted this cycle
//   core_rdata     read data, valid in the read's acceptance cycle
//   mem_valid      memory request valid
//   mem_we         memory write enable
//   mem_addr       memory address
//   mem_wdata      memory write data
//   mem_rdata      memory read data
//   mem_ready      memory accepts/completes the current request
//   wb_count       number of buffered writes outstanding

module albacore_biu #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int WBUF_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          core_req,
  input  logic                          core_we,
  input  logic [ADDR_W-1:0]             core_addr,
  input  logic [DATA_W-1:0]             core_wdata,
  output logic                          core_stall,
  output logic [DATA_W-1:0]             core_rdata,
  output logic                          mem_valid,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata,
  input  logic                          mem_ready,
  output logic [$clog2(WBUF_DEPTH):0]   wb_count
);

  localparam int PTR_W = $clog2(WBUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    READ  = 2'd2,
    RDONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_mem [WBUF_DEPTH];
  logic [DATA_W-1:0] data_mem [WBUF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              full, empty;
  logic              push, pop;
  logic              rd_pending;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  assign full       = (count_q == CNT_W'(WBUF_DEPTH));
  assign empty      = (count_q == '0);
  assign rd_pending = core_req && !core_we;

  // Full is judged on the registered count only, so a pop in the same cycle
  // cannot release a stalled write and mem_ready never reaches core_stall.
  assign push = core_req && core_we && !full;

  // The head is offered to memory whenever the buffer holds data and no read
  // owns the port. READ is only entered with an empty buffer, so the two
  // never compete.
  assign pop = !empty && (state_q != READ) && mem_ready;

`ifdef ALBACORE_BIU_FWD_EN
  // Scan entries oldest to newest; a later hit overrides an earlier one so
  // the newest matching write supplies the data.
  logic [PTR_W-1:0] fwd_idx;

  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      fwd_idx = rd_ptr_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (addr_mem[fwd_idx] == core_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_mem[fwd_idx];
      end
    end
  end
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

  // Read sequencing. DRAIN waits on the registered empty flag, which gives
  // a read behind N zero-wait writes an acceptance at N+2 cycles.
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (rd_pending) begin
          if (fwd_hit) begin
            state_d = RDONE;
            rdata_d = fwd_data;
          end else if (empty) begin
            state_d = READ;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (empty) begin
          state_d = READ;
        end
      end
      READ: begin
        if (mem_ready) begin
          rdata_d = mem_rdata;
          state_d = RDONE;
        end
      end
      RDONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Memory port. Fields are zero when idle; while valid they depend only on
  // registered state (or the held core_addr), so they stay stable until
  // mem_ready.
  always_comb begin
    mem_valid = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == READ) begin
      mem_valid = 1'b1;
      mem_addr  = core_addr;
    end else if (!empty) begin
      mem_valid = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = addr_mem[rd_ptr_q];
      mem_wdata = data_mem[rd_ptr_q];
    end
  end

  // Reads are accepted only in RDONE; writes only when the buffer has room.
  assign core_stall = core_req && (core_we ? full : (state_q != RDONE));
  assign core_rdata = rdata_q;
  assign wb_count   = count_q;

  // Control state. Reset discards any buffered writes by clearing pointers
  // and count, which also drops mem_valid at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rdata_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  // Buffer storage needs no reset: entries are only read below the count.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= core_addr;
      data_mem[wr_ptr_q] <= core_wdata;
    end
  end

endmodule
